// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared entry type and constants for the fetch queue
package fetch_queue_pkg;
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        pred_taken;
  } fq_entry_t;
  localparam logic [31:0] NOP_INSN = 32'h00000013;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side and decode-side handshake bundle of the fetch queue
interface fetch_queue_if #(parameter int DEPTH = 8);
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                in_insn;
  logic [31:0]                in_pc;
  logic                       in_pred_taken;
  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                out_insn;
  logic [31:0]                out_pc;
  logic                       out_pred_taken;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (
    output flush, in_valid, in_insn, in_pc, in_pred_taken, out_ready,
    input  in_ready, out_valid, out_insn, out_pc, out_pred_taken, count
  );
  modport slave (
    input  flush, in_valid, in_insn, in_pc, in_pred_taken, out_ready,
    output in_ready, out_valid, out_insn, out_pc, out_pred_taken, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode; FETCH_QUEUE_BYPASS_EN enables empty-queue pass-through
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fq_entry_t   mem [DEPTH];
  fq_entry_t   in_e, hd;
  logic [AW:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic        empty, full, byp, wr, rd;
  // Handshake, bypass selection and next-state pointers/count
  always_comb begin
    in_e  = '{insn: q.in_insn, pc: q.in_pc, pred_taken: q.in_pred_taken};
    empty = head_q == tail_q;
    full  = head_q[AW] != tail_q[AW] && head_q[AW-1:0] == tail_q[AW-1:0];
`ifdef FETCH_QUEUE_BYPASS_EN
    byp   = empty && q.in_valid && !q.flush;
`else
    byp   = 1'b0;
`endif
    hd               = byp ? in_e : mem[head_q[AW-1:0]];
    q.in_ready       = !full && !q.flush;
    q.out_valid      = !q.flush && (!empty || byp);
    q.out_insn       = q.out_valid ? hd.insn : NOP_INSN;
    q.out_pc         = q.out_valid ? hd.pc : 32'h0;
    q.out_pred_taken = q.out_valid && hd.pred_taken;
    q.count          = count_q;
    wr      = q.in_valid && q.in_ready && !(byp && q.out_ready);
    rd      = q.out_valid && q.out_ready && !byp;
    head_d  = q.flush ? '0 : head_q + (AW+1)'(rd);
    tail_d  = q.flush ? '0 : tail_q + (AW+1)'(wr);
    count_d = q.flush ? '0 : count_q + CW'(wr) - CW'(rd);
  end
  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Entry storage, written at tail on an accepted push
  always_ff @(posedge clk) begin
    if (wr) mem[tail_q[AW-1:0]] <= in_e;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue-based model
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int DEPTH = 8;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  fq_entry_t mdl[$];
  fetch_queue_if #(.DEPTH(DEPTH)) f();
  fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(f));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] insn, input logic [31:0] pc,
                       input logic pt, input logic ordy);
    f.flush = fl;
    f.in_valid = iv;
    f.in_insn = insn;
    f.in_pc = pc;
    f.in_pred_taken = pt;
    f.out_ready = ordy;
  endtask

  task automatic cycle(input logic fl, input logic iv, input logic [31:0] insn, input logic [31:0] pc,
                       input logic pt, input logic ordy);
    fq_entry_t e, hd;
    logic ev, er, byp;
    drive(fl, iv, insn, pc, pt, ordy);
    #2;
    e = fq_entry_t'{insn, pc, pt};
    byp = BYP && mdl.size() == 0 && iv && !fl;
    ev = !fl && (mdl.size() > 0 || byp);
    er = !fl && mdl.size() < DEPTH;
    hd = !ev ? fq_entry_t'{NOP_INSN, 32'h0, 1'b0} : (mdl.size() > 0 ? mdl[0] : e);
    chk("out_valid", 32'(f.out_valid), 32'(ev));
    chk("in_ready", 32'(f.in_ready), 32'(er));
    chk("out_insn", f.out_insn, hd.insn);
    chk("out_pc", f.out_pc, hd.pc);
    chk("out_pred", 32'(f.out_pred_taken), 32'(hd.pred_taken));
    chk("count", 32'(f.count), 32'(mdl.size()));
    if (fl) mdl.delete();
    else if (!(byp && ordy)) begin
      if (ev && ordy) void'(mdl.pop_front());
      if (iv && er) mdl.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_count", 32'(f.count), 0);
    chk("rst_out_valid", 32'(f.out_valid), 0);
    chk("rst_in_ready", 32'(f.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h1000 + i, 32'(4 * i), i[0], 0);
    chk("count3", 32'(f.count), 3);
    chk("head_pc0", f.out_pc, 0);
    chk("ready3", 32'(f.in_ready), 1);
    for (int i = 3; i < DEPTH; i++) cycle(0, 1, 32'h1000 + i, 32'(4 * i), i[0], 0);
    chk("full_ready", 32'(f.in_ready), 0);
    chk("full_count", 32'(f.count), 8);
    cycle(0, 1, 32'hdead, 32'h20, 1, 0);
    cycle(0, 1, 32'hbeef, 32'h24, 0, 1);
    chk("full_pop_count", 32'(f.count), 7);
    chk("full_pop_ready", 32'(f.in_ready), 1);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 0, 1);
    chk("drained", 32'(f.count), 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, $urandom, 32'h100 + 32'(4 * i), 1'($urandom), 1);
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, $urandom, 32'h400 + 32'(4 * i), 0, 0);
    cycle(1, 1, 32'h77, 32'h500, 1, 1);
    chk("flush_count", 32'(f.count), 0);
    chk("flush_out_insn", f.out_insn, NOP_INSN);
    cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, $urandom, 32'h600 + 32'(4 * i), 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(f.count), 0);
    chk("arst_out_valid", 32'(f.out_valid), 0);
    mdl.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1, 32'h00500093, 32'h200, 0, 0);
    #2;
    chk("bypass_insn", f.out_insn, BYP ? 32'h00500093 : NOP_INSN);
    mdl.push_back(fq_entry_t'{32'h00500093, 32'h200, 1'b0});
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 15) == 0, 1'($urandom), $urandom, $urandom, 1'($urandom),
            $urandom_range(0, 2) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
